// File: rtl/toggle_cover_scheduler.sv
// Toggle-coverage collector: records first hits in a sticky bitmap and streams
// newly hit points as absolute cover indices, round-robin, one per cycle.
module toggle_cover_scheduler #(
    parameter int unsigned WIDTH       = 27,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8940,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             enable,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_hit
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = $clog2(WIDTH + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
        $error("toggle_cover_scheduler: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
    if (WIDTH < 1 || WIDTH > 1024) begin : g_width_err
        $error("toggle_cover_scheduler: WIDTH must be in 1..1024");
    end

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_seen;
    logic [WIDTH-1:0]  r_pending;
    logic [IW-1:0]     r_ptr;
    logic              r_out_valid;
    logic [63:0]       r_out_index;
    logic [CNT_W-1:0]  r_hit_count;
    logic              r_all_hit;

    logic [WIDTH-1:0]  w_ev;
    logic [WIDTH-1:0]  w_new;
    logic [WIDTH-1:0]  w_seen_next;
    logic [WIDTH-1:0]  w_hi_mask;
    logic [WIDTH-1:0]  w_cand;
    logic [WIDTH-1:0]  w_grant_oh;
    logic [WIDTH-1:0]  w_pending_next;
    logic [IW-1:0]     w_g;
    logic [IW-1:0]     w_ptr_next;
    logic              w_have;
    logic              w_load;
    logic              w_grant;
    logic [PW-1:0]     w_pop;
    logic [SW-1:0]     w_sum;
    logic [CNT_W-1:0]  w_hc_next;
    logic [63:0]       w_idx;

    function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt = cnt + PW'(v[i]);
        end
        return cnt;
    endfunction

    // Event filtering and sticky bitmap update
    always_comb begin
        w_ev        = valid & {WIDTH{enable}};
        w_new       = clear ? w_ev : (w_ev & ~r_seen);
        w_seen_next = clear ? w_ev : (r_seen | w_ev);
    end

    // Round-robin pick: lowest pending bit at/after ptr, else lowest overall
    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_hi_mask[i] = (i >= int'(r_ptr));
        end
        w_cand = ((r_pending & w_hi_mask) != '0) ? (r_pending & w_hi_mask) : r_pending;
        w_g    = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_g = IW'(i);
            end
        end
    end

    always_comb begin
        w_have         = (r_pending != '0);
        w_load         = (r_state == ST_EMPTY) || out_ready;
        w_grant        = w_load && w_have;
        w_grant_oh     = w_grant ? (WIDTH'(1) << w_g) : '0;
        // new set bits override a same-cycle grant clear
        w_pending_next = (r_pending & ~w_grant_oh) | w_new;
        w_ptr_next     = (w_g == IW'(WIDTH - 1)) ? '0 : (w_g + IW'(1));
        w_idx          = 64'(COVER_INDEX) + 64'(w_g);
    end

    // Saturating unique-hit count; clear restarts from this cycle's events
    always_comb begin
        w_pop     = popcnt(w_new);
        w_sum     = clear ? SW'(w_pop) : (SW'(r_hit_count) + SW'(w_pop));
        w_hc_next = (w_sum > SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_seen      <= '0;
            r_pending   <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_hit_count <= '0;
            r_all_hit   <= 1'b0;
        end else begin
            r_seen      <= w_seen_next;
            r_pending   <= w_pending_next;
            r_hit_count <= w_hc_next;
            r_all_hit   <= &r_seen;
            case (r_state)
                ST_EMPTY, ST_FULL: begin
                    if (w_load) begin
                        if (w_have) begin
                            r_state     <= ST_FULL;
                            r_out_valid <= 1'b1;
                            r_out_index <= w_idx;
                            r_ptr       <= w_ptr_next;
                        end else begin
                            r_state     <= ST_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign hit_count = r_hit_count;
    assign all_hit   = r_all_hit;

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Directed bench for toggle_cover_scheduler: latency, round-robin order, stall,
// duplicate suppression, clear, enable gating, reset and counter saturation.
module tb_toggle_cover_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [26:0] valid;
    logic        enable;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_index;
    logic [15:0] hit_count;
    logic        all_hit;

    logic [26:0] s_valid;
    logic        s_clear;
    logic        s_ready;
    logic        s_out_valid;
    logic [63:0] s_out_index;
    logic [3:0]  s_hit_count;
    logic        s_all_hit;

    int n_total = 0;
    int n_bad   = 0;

    toggle_cover_scheduler #(
        .WIDTH(27), .COVER_INDEX(100), .COVER_TOTAL(8940), .CNT_W(16)
    ) u_dut (
        .clock(clock), .reset(reset), .valid(valid), .enable(enable),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .hit_count(hit_count), .all_hit(all_hit)
    );

    toggle_cover_scheduler #(
        .WIDTH(27), .COVER_INDEX(0), .COVER_TOTAL(8940), .CNT_W(4)
    ) u_sat (
        .clock(clock), .reset(reset), .valid(s_valid), .enable(enable),
        .clear(s_clear), .out_valid(s_out_valid), .out_ready(s_ready),
        .out_index(s_out_index), .hit_count(s_hit_count), .all_hit(s_all_hit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
        s_valid = '0; s_clear = 1'b0; s_ready = 1'b1;

        // single hit: two-cycle latency, one-cycle pulse
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_index", out_index, 64'd0);
        chk("rst_count", 64'(hit_count), 64'd0);
        chk("rst_allhit", 64'(all_hit), 64'd0);
        valid = 27'h1;
        tick();
        valid = '0;
        chk("s1_early", 64'(out_valid), 64'd0);
        tick();
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_index", out_index, 64'd100);
        chk("s1_count", 64'(hit_count), 64'd1);
        tick();
        chk("s1_drop", 64'(out_valid), 64'd0);

        // all points at once: contiguous 100..126
        do_reset();
        valid = '1;
        tick();
        valid = '0;
        chk("s2_count", 64'(hit_count), 64'd27);
        chk("s2_allhit_lag", 64'(all_hit), 64'd0);
        tick();
        chk("s2_allhit", 64'(all_hit), 64'd1);
        chk("s2_v0", 64'(out_valid), 64'd1);
        chk("s2_i0", out_index, 64'd100);
        for (int k = 1; k < 27; k++) begin
            tick();
            chk("s2_v", 64'(out_valid), 64'd1);
            chk("s2_i", out_index, 64'(100 + k));
        end
        tick();
        chk("s2_end", 64'(out_valid), 64'd0);

        // stall with bits 3,5,20 then drain; later bit 1 wraps the pointer
        do_reset();
        out_ready = 1'b0;
        valid = 27'h010_0028;
        tick();
        valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s3_stall_v", 64'(out_valid), 64'd1);
            chk("s3_stall_i", out_index, 64'd103);
        end
        out_ready = 1'b1;
        tick();
        chk("s3_i105", out_index, 64'd105);
        tick();
        chk("s3_i120", out_index, 64'd120);
        chk("s3_v120", 64'(out_valid), 64'd1);
        tick();
        chk("s3_empty", 64'(out_valid), 64'd0);
        valid = 27'h2;
        tick();
        valid = '0;
        tick();
        chk("s3_wrap_v", 64'(out_valid), 64'd1);
        chk("s3_wrap_i", out_index, 64'd101);
        chk("s3_count", 64'(hit_count), 64'd4);

        // duplicate suppression, then clear re-arms bit 4
        do_reset();
        valid = 27'h10;
        tick();
        valid = '0;
        tick();
        chk("s4_first", out_index, 64'd104);
        tick();
        valid = 27'h10;
        tick();
        valid = '0;
        tick();
        chk("s4_dup_v", 64'(out_valid), 64'd0);
        chk("s4_dup_cnt", 64'(hit_count), 64'd1);
        tick();
        chk("s4_dup_v2", 64'(out_valid), 64'd0);
        clear = 1'b1;
        valid = 27'h10;
        tick();
        clear = 1'b0;
        valid = '0;
        chk("s4_clr_cnt", 64'(hit_count), 64'd1);
        tick();
        chk("s4_clr_v", 64'(out_valid), 64'd1);
        chk("s4_clr_i", out_index, 64'd104);
        tick();
        chk("s4_clr_end", 64'(out_valid), 64'd0);

        // enable gating
        do_reset();
        enable = 1'b0;
        valid = '1;
        tick();
        tick();
        chk("s5_en_v", 64'(out_valid), 64'd0);
        chk("s5_en_cnt", 64'(hit_count), 64'd0);
        valid = '0;
        enable = 1'b1;

        // reset while FULL with 10 still pending
        out_ready = 1'b0;
        valid = 27'h7FF;
        tick();
        valid = '0;
        tick();
        chk("s5_full_v", 64'(out_valid), 64'd1);
        chk("s5_full_i", out_index, 64'd100);
        chk("s5_full_cnt", 64'(hit_count), 64'd11);
        do_reset();
        chk("s5_rst_v", 64'(out_valid), 64'd0);
        chk("s5_rst_cnt", 64'(hit_count), 64'd0);
        chk("s5_rst_i", out_index, 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("s5_flushed", 64'(out_valid), 64'd0);

        // 4-bit counter saturates and restarts on clear
        s_clear = 1'b1;
        s_valid = '1;
        tick();
        chk("s6_sat1", 64'(s_hit_count), 64'd15);
        tick();
        chk("s6_sat2", 64'(s_hit_count), 64'd15);
        s_clear = 1'b0;
        tick();
        chk("s6_hold", 64'(s_hit_count), 64'd15);
        s_clear = 1'b1;
        s_valid = 27'h7;
        tick();
        s_clear = 1'b0;
        s_valid = '0;
        chk("s6_reclr", 64'(s_hit_count), 64'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
